// File: rtl/hack_mem_pkg.sv
// Shared types and helpers for the Hack A/D/RAM memory stage.
// Holds FSM encoding, default widths and the address range check.
package hack_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } mem_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RAM_AW = 4;

    // True when no address bit at or above aw is set.
    function automatic logic addr_in_range(
        input logic [63:0] addr,
        input int          aw
    );
        return (addr >> aw) == 64'd0;
    endfunction

endpackage

// File: rtl/hack_ram.sv
// Single-port data RAM: synchronous write, asynchronous read.
// Owns only the storage array; no reset of its contents.
module hack_ram #(
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**AW];

    // Write port: one word per rising edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/hack_mem_unit.sv
// A/D registers plus data RAM with a post-reset clear sequencer.
// Define MEM_ADDR_CHECK_EN to trap out-of-range A on RAM access.
module hack_mem_unit
    import hack_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RAM_AW = DEF_RAM_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_store_ram,
    input  logic              i_store_d,
    input  logic              i_store_a,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_out_a,
    output logic [DATA_W-1:0] o_out_d,
    output logic [DATA_W-1:0] o_out_ram,
    output logic              o_ready,
    output logic              o_addr_fault
);

    mem_state_t        r_state;
    logic [RAM_AW-1:0] r_cnt;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;

    logic              w_run;
    logic              w_in_range;
    logic              w_we;
    logic [RAM_AW-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_run = (r_state == ST_RUN);

`ifdef MEM_ADDR_CHECK_EN
    assign w_in_range = addr_in_range(64'(r_a), RAM_AW);
`else
    assign w_in_range = 1'b1;
`endif

    // The clear sequencer owns the RAM port until RUN.
    assign w_addr  = w_run ? r_a[RAM_AW-1:0] : r_cnt;
    assign w_we    = w_run ? (i_store_ram & w_in_range) : 1'b1;
    assign w_wdata = w_run ? i_din : '0;

    hack_ram #(
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Clear sequencer: sweep every RAM word once, then run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // A and D registers accept stores only once running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_d <= '0;
        end else if (w_run) begin
            if (i_store_a) r_a <= i_din;
            if (i_store_d) r_d <= i_din;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    logic r_fault;

    // Sticky flag for a RAM store attempted with A out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_run && i_store_ram && !w_in_range) begin
            r_fault <= 1'b1;
        end
    end

    assign o_addr_fault = r_fault;
`else
    assign o_addr_fault = 1'b0;
`endif

    assign o_out_a   = r_a;
    assign o_out_d   = r_d;
    assign o_out_ram = (w_run && w_in_range) ? w_rdata : '0;
    assign o_ready   = w_run;

endmodule
